// File: rtl/bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_pkg : shared types and defaults for the system bus arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bus_pkg;

  localparam int N_MASTERS_DEF = 8;
  localparam int ID_W_DEF      = 3;
  localparam int MAX_BEATS_DEF = 8;
  localparam int TIMEOUT_DEF   = 255;

  localparam int ICACHE = 0;
  localparam int DCACHE = 1;
  localparam int DMA0   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } bus_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : first set request at or after ptr+1, wrapping (N = 2**IDW)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  logic [IDW-1:0] w_start;
  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_enc;

  assign w_start = ptr_i + IDW'(1);

  // Rotate so the highest-priority candidate sits at bit 0; IDW-bit
  // arithmetic provides the modulo-N wrap.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      w_rot[i] = req_i[IDW'(i) + w_start];
    end
  end

  always_comb begin
    w_enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_enc = IDW'(i);
      end
    end
  end

  assign found_o = |req_i;
  assign idx_o   = w_enc + w_start;

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_arbiter_rr : round-robin bus arbiter with turnaround, burst cap   |
// | and slave timeout.  Rev 1.0                                          |
// +----------------------------------------------------------------------+
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int N_MASTERS = N_MASTERS_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int MAX_BEATS = MAX_BEATS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N_MASTERS-1:0] DMA,
  input  logic                 BUS_ready,
  output logic [N_MASTERS-1:0] grant,
  output logic                 BUS_req,
  output logic [ID_W-1:0]      owner,
  output logic                 bus_busy,
  output logic                 timeout_err,
  output logic [ID_W-1:0]      err_id
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  bus_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic                 breq_q, breq_d;
  logic [ID_W-1:0]      owner_q, owner_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;
  logic [ID_W-1:0]      errid_q, errid_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;

  logic                 w_found;
  logic [ID_W-1:0]      w_pick;
  logic                 w_tmo;
  logic                 w_rel;
  logic                 w_cap;

  rr_pick #(
    .N   (N_MASTERS),
    .IDW (ID_W)
  ) u_pick (
    .req_i   (DMA),
    .ptr_i   (ptr_q),
    .found_o (w_found),
    .idx_o   (w_pick)
  );

  // A ready beat on the expiry edge cancels the timeout.
  assign w_tmo = !BUS_ready && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign w_rel = !DMA[owner_q];
  assign w_cap = BUS_ready && (beat_q >= BEAT_W'(MAX_BEATS - 1)) && |(DMA & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    breq_d  = breq_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    terr_d  = 1'b0;
    errid_d = errid_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d         = OWN;
          grant_d         = '0;
          grant_d[w_pick] = 1'b1;
          breq_d          = 1'b1;
          owner_d         = w_pick;
          busy_d          = 1'b1;
          ptr_d           = w_pick;
          beat_d          = '0;
          tmo_d           = '0;
        end
      end
      OWN: begin
        if (BUS_ready) begin
          if (beat_q != BEAT_W'(MAX_BEATS)) begin
            beat_d = beat_q + BEAT_W'(1);
          end
          tmo_d = '0;
        end else if (tmo_q != TMO_W'(TIMEOUT)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (w_tmo || w_rel || w_cap) begin
          state_d = TURN;
          grant_d = '0;
          breq_d  = 1'b0;
          busy_d  = 1'b0;
        end
        if (w_tmo) begin
          terr_d  = 1'b1;
          errid_d = owner_q;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      grant_q <= '0;
      breq_q  <= 1'b0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      errid_q <= '0;
      ptr_q   <= ID_W'(N_MASTERS - 1);
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      breq_q  <= breq_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      errid_q <= errid_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant       = grant_q;
  assign BUS_req     = breq_q;
  assign owner       = owner_q;
  assign bus_busy    = busy_q;
  assign timeout_err = terr_q;
  assign err_id      = errid_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// Directed bench for bus_arbiter_rr and its rr_pick helper.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] DMA = 8'h00;
  logic       BUS_ready = 1'b0;
  logic [7:0] grant;
  logic       BUS_req;
  logic [2:0] owner;
  logic       bus_busy;
  logic       timeout_err;
  logic [2:0] err_id;

  logic [7:0] pk_req = 8'h00;
  logic [2:0] pk_ptr = 3'd0;
  logic       pk_found;
  logic [2:0] pk_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr dut (
    .clk         (clk),
    .clr         (clr),
    .DMA         (DMA),
    .BUS_ready   (BUS_ready),
    .grant       (grant),
    .BUS_req     (BUS_req),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err),
    .err_id      (err_id)
  );

  rr_pick #(.N(8), .IDW(3)) u_pick (
    .req_i   (pk_req),
    .ptr_i   (pk_ptr),
    .found_o (pk_found),
    .idx_o   (pk_idx)
  );

  typedef struct {
    logic       clr;
    logic [7:0] dma;
    logic       rdy;
    logic [7:0] g;
    logic       breq;
    logic [2:0] own;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [7:0] req;
    logic [2:0] ptr;
    logic       found;
    logic [2:0] idx;
  } pk_t;

  vec_t vq[$];
  pk_t  pq[$];

  task automatic add(input logic c, input logic [7:0] d, input logic r,
                     input logic [7:0] g, input logic b, input logic [2:0] o,
                     input logic y);
    vec_t v;
    v.clr = c; v.dma = d; v.rdy = r; v.g = g; v.breq = b; v.own = o; v.busy = y;
    vq.push_back(v);
  endtask

  task automatic addp(input logic [7:0] r, input logic [2:0] p, input logic f,
                      input logic [2:0] i);
    pk_t v;
    v.req = r; v.ptr = p; v.found = f; v.idx = i;
    pq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic [7:0] d, input logic r);
    clr = c; DMA = d; BUS_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rr_pick unit vectors
    addp(8'h01, 3'd7, 1'b1, 3'd0);
    addp(8'h01, 3'd0, 1'b1, 3'd0);
    addp(8'h06, 3'd0, 1'b1, 3'd1);
    addp(8'h06, 3'd1, 1'b1, 3'd2);
    addp(8'h06, 3'd2, 1'b1, 3'd1);
    addp(8'h80, 3'd3, 1'b1, 3'd7);
    addp(8'h81, 3'd7, 1'b1, 3'd0);
    addp(8'hFF, 3'd4, 1'b1, 3'd5);
    addp(8'hFF, 3'd7, 1'b1, 3'd0);
    addp(8'h48, 3'd6, 1'b1, 3'd3);
    addp(8'h00, 3'd5, 1'b0, 3'd0);

    // arbiter cycle vectors: inputs for a cycle, outputs after its edge
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    add(1, 8'h01, 0, 8'h00, 0, 0, 0);
    add(0, 8'h01, 0, 8'h01, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(0, 8'h07, 1, 8'h01, 1, 0, 1);
    add(0, 8'h06, 0, 8'h00, 0, 0, 0);
    add(0, 8'h06, 0, 8'h00, 0, 0, 0);
    add(0, 8'h06, 0, 8'h02, 1, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 8'h07, 1, 8'h02, 1, 1, 1);
    add(0, 8'h05, 0, 8'h00, 0, 1, 0);
    add(0, 8'h07, 0, 8'h00, 0, 1, 0);
    add(0, 8'h07, 0, 8'h04, 1, 2, 1);
    add(0, 8'h03, 0, 8'h00, 0, 2, 0);
    add(0, 8'h03, 0, 8'h00, 0, 2, 0);
    add(0, 8'h03, 0, 8'h01, 1, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 8'h01, 0, 8'h01, 1, 0, 1);
    for (int i = 0; i < 7; i++) add(0, 8'h09, 1, 8'h01, 1, 0, 1);
    add(0, 8'h09, 1, 8'h00, 0, 0, 0);
    add(0, 8'h09, 0, 8'h00, 0, 0, 0);
    add(0, 8'h09, 0, 8'h08, 1, 3, 1);
    add(0, 8'h01, 0, 8'h00, 0, 3, 0);
    add(0, 8'h01, 0, 8'h00, 0, 3, 0);
    add(0, 8'h01, 0, 8'h01, 1, 0, 1);

    foreach (pq[i]) begin
      pk_req = pq[i].req;
      pk_ptr = pq[i].ptr;
      #1;
      chk($sformatf("pick_found[%0d]", i), 32'(pk_found), 32'(pq[i].found));
      if (pq[i].found) chk($sformatf("pick_idx[%0d]", i), 32'(pk_idx), 32'(pq[i].idx));
    end

    foreach (vq[i]) begin
      step(vq[i].clr, vq[i].dma, vq[i].rdy);
      chk($sformatf("vec[%0d] {grant,req,owner,busy,terr,errid}", i),
          32'({grant, BUS_req, owner, bus_busy, timeout_err, err_id}),
          32'({vq[i].g, vq[i].breq, vq[i].own, vq[i].busy, 1'b0, 3'd0}));
    end

    // no competitor: tenure survives past the beat cap
    for (int i = 0; i < 12; i++) begin
      step(0, 8'h01, 1);
      chk("nocap_grant", 32'(grant), 32'h01);
    end
    step(0, 8'h00, 0);
    chk("nocap_release", 32'(grant), 32'h00);
    step(0, 8'h00, 0);

    // timeout on master 2
    step(0, 8'h04, 0);
    chk("tmo_grant", 32'({grant, owner}), 32'({8'h04, 3'd2}));
    for (int k = 1; k < 255; k++) begin
      step(0, 8'h04, 0);
      chk("tmo_hold", 32'({grant, timeout_err}), 32'({8'h04, 1'b0}));
    end
    step(0, 8'h04, 0);
    chk("tmo_fire", 32'({grant, BUS_req, bus_busy, timeout_err, err_id}),
        32'({8'h00, 1'b0, 1'b0, 1'b1, 3'd2}));
    step(0, 8'h04, 0);
    chk("tmo_pulse_end", 32'({grant, timeout_err, err_id}), 32'({8'h00, 1'b0, 3'd2}));
    step(0, 8'h04, 0);
    chk("tmo_regrant", 32'({grant, owner}), 32'({8'h04, 3'd2}));
    for (int k = 1; k < 255; k++) step(0, 8'h04, 0);
    step(0, 8'h04, 1);
    chk("tmo_cancel", 32'({grant, timeout_err}), 32'({8'h04, 1'b0}));
    for (int k = 0; k < 5; k++) begin
      step(0, 8'h04, 0);
      chk("tmo_restart", 32'({grant, timeout_err}), 32'({8'h04, 1'b0}));
    end
    step(0, 8'h00, 0);
    chk("tmo_release", 32'({grant, timeout_err, err_id}), 32'({8'h00, 1'b0, 3'd2}));
    step(0, 8'h00, 0);

    // release coinciding with the 8th beat and a waiting competitor
    step(0, 8'h01, 0);
    chk("sim_grant", 32'({grant, owner}), 32'({8'h01, 3'd0}));
    for (int i = 0; i < 7; i++) step(0, 8'h01, 1);
    step(0, 8'h02, 1);
    chk("sim_release", 32'({grant, BUS_req, timeout_err}), 32'({8'h00, 1'b0, 1'b0}));
    step(0, 8'h02, 0);
    chk("sim_turn", 32'({grant, timeout_err}), 32'({8'h00, 1'b0}));
    step(0, 8'h02, 0);
    chk("sim_next", 32'({grant, owner}), 32'({8'h02, 3'd1}));

    // reset mid-tenure
    step(1, 8'hFF, 0);
    chk("rst_mid", 32'({grant, BUS_req, owner, bus_busy, timeout_err, err_id}), 32'(0));
    step(0, 8'hFF, 0);
    chk("rst_first", 32'({grant, BUS_req, owner, bus_busy}), 32'({8'h01, 1'b1, 3'd0, 1'b1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Round-robin arbiter for the shared system bus (BUS_addr/BUS_data/BUS_RW/BUS_ready) used by I-cache, D-cache and DMA masters. It collects one request line per master and issues a one-hot grant to exactly one owner. It enforces a turnaround cycle between owners, limits burst length so one master cannot starve the others, and revokes the grant from a master whose slave never answers. It drives BUS_req toward the memory slave while a transaction owner holds the bus.

Parameters:
N_MASTERS, 8, number of request/grant lines; fixed at 8 in this design.
ID_W, 3, width of owner/error id (clog2 N_MASTERS).
MAX_BEATS, 8, BUS_ready pulses allowed per tenure before forced re-arbitration (cache line = 4 words; 8 gives margin).
TIMEOUT, 255, cycles allowed in OWN without BUS_ready before the grant is revoked.

Ports:
clk  in  1  system clock, all state on rising edge
clr  in  1  synchronous, active-high reset
DMA  in  N_MASTERS  request lines; bit i held high by master i for its whole tenure
BUS_ready  in  1  slave beat-complete strobe, one cycle per word
grant  out  N_MASTERS  one-hot grant, registered
BUS_req  out  1  bus transaction active toward slave, registered
owner  out  ID_W  index of current grantee; valid when bus_busy=1
bus_busy  out  1  high in OWN
timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout
err_id  out  ID_W  id of the master last revoked; held until next timeout or reset

Behaviour:
- Single clock domain (clk); reset is synchronous, active-high, on clr.
- Reset (clr=1 at edge): state=IDLE, grant=0, BUS_req=0, owner=0, bus_busy=0, timeout_err=0, err_id=0, rr pointer=N_MASTERS-1 (master 0 wins first), beat and timeout counters=0. clr mid-tenure drops grant and BUS_req on the same edge; no turnaround cycle.
- States: IDLE, OWN, TURN.
- IDLE: if DMA!=0, pick the first set bit searching upward from ptr+1, modulo N_MASTERS. On that edge: grant=onehot(pick), owner=pick, BUS_req=1, bus_busy=1, ptr=pick, counters cleared, state=OWN. Request-to-grant latency is one cycle.
- OWN:
  - Each BUS_ready increments beat_cnt and clears tmo_cnt. Cycles without BUS_ready increment tmo_cnt.
  - Exit to TURN, with grant=0, BUS_req=0 and bus_busy=0 on the exit edge, when any of these holds:
    - (a) DMA[owner]=0, normal release;
    - (b) beat_cnt reaches MAX_BEATS on a BUS_ready edge and some other DMA bit is set. With no competitor the tenure continues and beat_cnt saturates;
    - (c) tmo_cnt reaches TIMEOUT. On that edge timeout_err=1 for one cycle and err_id=owner.
  - Priority when several hold on the same edge: c > a > b. BUS_ready arriving on the timeout edge cancels the timeout.
  - A beat completing on the same edge as the release counts; release still occurs.
- TURN: exactly one cycle with all grants low, for tri-state handover. Next state is always IDLE, and arbitration happens there. Minimum owner-to-owner gap is therefore 2 cycles of grant=0.
- A master that keeps DMA high after a forced release is simply another requester. Round-robin from ptr guarantees every requester wins within N_MASTERS tenures.
- grant is never multi-hot; grant!=0 iff state=OWN. Requests that rise and fall while another master owns the bus are not latched.
- Counter widths: beat_cnt clog2(MAX_BEATS+1), saturating; tmo_cnt clog2(TIMEOUT+1), saturating.

Decomposition:
- Package bus_pkg: state enum {IDLE, OWN, TURN}, N_MASTERS, ID_W, MAX_BEATS, TIMEOUT defaults, and master index constants (ICACHE=0, DCACHE=1, DMA0=2).
- Sub-module rr_pick: combinational; inputs req[N], ptr[ID_W]; outputs found and idx. Implement by rotate, priority-encode, un-rotate. Unit-test it separately.

Test Plan:
- Reset/first grant: clr for 2 cycles, then DMA=8'b0000_0001 -> one cycle later grant=01, BUS_req=1, owner=0; all outputs 0 during clr.
- Round-robin: DMA=8'b0000_0111 held; each master releases after 4 BUS_ready -> grant order 01,02,04,01,...; each handover shows 1 TURN plus 1 IDLE cycle with grant=0.
- Burst cap: master 0 holds DMA with BUS_ready every cycle, master 3 requests -> after 8th BUS_ready grant drops; next grant=08. With master 3 idle, master 0 keeps the grant past 8 beats.
- Timeout: master 2 granted, BUS_ready held 0 -> on cycle 255 of OWN grant=0, timeout_err pulses once, err_id=2; BUS_ready on cycle 255 instead -> no error.
- Simultaneous: DMA[owner] falls on the same edge as a BUS_ready that completes beat 8 -> single release, beat counted, no error.
- Reset mid-tenure: clr asserted in OWN -> grant=0, BUS_req=0 at that edge, ptr=7; after clr drops with DMA=8'hFF the next grant=01.
